instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the IM block.
- Holds the program counter and drives InstrAddr to IM; IM returns the big-endian 32-bit Instr combinationally in the same cycle.
- Latches PC and Instr into an IF/ID output register with a valid/ready handshake toward decode.
- Handles stall, redirect/flush, an end-of-memory halt and an address-fault halt.

---
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 tb/tb_instr_fetch_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, presents it to IM, and registers
// the returned word into the IF/ID register toward decode.
// Handles stall, redirect/flush, end-of-memory halt and sticky address fault.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          INSTR_MAX = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] InstrAddr,
  input  logic [31:0] Instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        IFID_Valid,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_Instr,
  output logic        halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
`endif
  output logic        fault
);

  // Address of the final word; fetching it ends the run.
  localparam logic [31:0] LAST_PC = 32'(INSTR_MAX - 4);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        ifid_valid_n;
  logic [31:0] ifid_pc_n, ifid_instr_n;
  logic        fault_n;
  logic        advance, redir_take, redir_ok;

  assign InstrAddr = pc;
  assign halted    = (state == HALT);
  assign advance   = (state == RUN) && (!IFID_Valid || id_ready);
  // A latched fault locks out redirects until reset; IDLE ignores them too.
  assign redir_take = redirect_valid && (state != IDLE) && !fault;
  assign redir_ok   = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= LAST_PC);

  // State, PC and IF/ID register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      IFID_Valid <= 1'b0;
      IFID_PC    <= '0;
      IFID_Instr <= '0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      IFID_Valid <= ifid_valid_n;
      IFID_PC    <= ifid_pc_n;
      IFID_Instr <= ifid_instr_n;
      fault      <= fault_n;
    end
  end

  // Next-state: redirect beats advance beats hold.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    ifid_valid_n = IFID_Valid;
    ifid_pc_n    = IFID_PC;
    ifid_instr_n = IFID_Instr;
    fault_n      = fault;
    if (state == IDLE) begin
      // One bubble after reset, nothing fetched.
      state_n = RUN;
    end else if (redir_take) begin
      ifid_valid_n = 1'b0;
      if (redir_ok) begin
        pc_n    = redirect_pc;
        state_n = RUN;
      end else begin
        fault_n = 1'b1;
        state_n = HALT;
      end
    end else if (advance) begin
      ifid_pc_n    = pc;
      ifid_instr_n = Instr;
      ifid_valid_n = 1'b1;
      if (pc == LAST_PC) state_n = HALT;
      else               pc_n    = pc + 32'd4;
    end else if (state == HALT && id_ready) begin
      // Last instruction drains to decode, nothing new is fetched.
      ifid_valid_n = 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters of fetches and decode-backpressure cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (advance && fetch_count != 32'hFFFF_FFFF)
        fetch_count <= fetch_count + 32'd1;
      if (state == RUN && IFID_Valid && !id_ready && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a byte-ramp IM model (byte i = i).
module tb_instr_fetch_unit;

  logic        clk, rst_n;
  logic [31:0] InstrAddr, Instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        IFID_Valid;
  logic [31:0] IFID_PC, IFID_Instr;
  logic        halted, fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
`endif

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.RESET_PC(32'h0), .INSTR_MAX(128)) dut (
    .clk(clk), .rst_n(rst_n), .InstrAddr(InstrAddr), .Instr(Instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .IFID_Valid(IFID_Valid), .IFID_PC(IFID_PC),
    .IFID_Instr(IFID_Instr), .halted(halted),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count(fetch_count), .stall_count(stall_count),
`endif
    .fault(fault)
  );

  // IM: big-endian word of consecutive byte values, zero outside memory.
  logic [7:0] a0;
  assign a0 = InstrAddr[7:0];
  assign Instr = (InstrAddr < 32'd128) ?
                 {a0, a0 + 8'd1, a0 + 8'd2, a0 + 8'd3} : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] epc, input logic [31:0] ein);
    chk({tag, "_v"},   {31'b0, IFID_Valid}, 32'd1);
    chk({tag, "_pc"},  IFID_PC, epc);
    chk({tag, "_ins"}, IFID_Instr, ein);
  endtask

  initial begin
    rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    chk("rst_valid", {31'b0, IFID_Valid}, 32'd0);
    chk("rst_pc", IFID_PC, 32'h0);
    chk("rst_instr", IFID_Instr, 32'h0);
    chk("rst_addr", InstrAddr, 32'h0);
    chk("rst_halt", {31'b0, halted}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);

    // Release mid-cycle; first edge is the IDLE bubble.
    rst_n = 1'b1;
    step();
    chk("bubble_v", {31'b0, IFID_Valid}, 32'd0);
    chk("bubble_addr", InstrAddr, 32'h0);
    step(); chk_ifid("f0", 32'h0, 32'h00010203);
    step(); chk_ifid("f4", 32'h4, 32'h04050607);
    step(); chk_ifid("f8", 32'h8, 32'h08090A0B);

    // Three stall cycles while IFID holds PC 8.
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", IFID_PC, 32'h8);
      chk("stall_addr", InstrAddr, 32'hC);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt", stall_count, 32'd3);
`endif
    id_ready = 1'b1;
    step(); chk_ifid("f12", 32'hC, 32'h0C0D0E0F);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", fetch_count, 32'd4);
`endif

    // Redirect while stalled flushes IFID.
    id_ready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    chk("redir_v", {31'b0, IFID_Valid}, 32'd0);
    chk("redir_addr", InstrAddr, 32'h40);
    redirect_valid = 1'b0; id_ready = 1'b1;
    step(); chk_ifid("f40", 32'h40, 32'h40414243);

    // Run 0x44..0x7C (15 fetches) to end of memory.
    repeat (15) step();
    chk_ifid("flast", 32'h7C, 32'h7C7D7E7F);
    chk("end_halt", {31'b0, halted}, 32'd1);
    chk("end_addr", InstrAddr, 32'h7C);
    step();
    chk("drain_v", {31'b0, IFID_Valid}, 32'd0);
    chk("drain_halt", {31'b0, halted}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    chk("resume_halt", {31'b0, halted}, 32'd0);
    chk("resume_addr", InstrAddr, 32'h10);
    redirect_valid = 1'b0;
    step(); chk_ifid("f10", 32'h10, 32'h10111213);

    // Misaligned redirect faults; PC stays at 0x14.
    redirect_valid = 1'b1; redirect_pc = 32'h02;
    step();
    redirect_valid = 1'b0;
    chk("mis_fault", {31'b0, fault}, 32'd1);
    chk("mis_halt", {31'b0, halted}, 32'd1);
    chk("mis_v", {31'b0, IFID_Valid}, 32'd0);
    chk("mis_addr", InstrAddr, 32'h14);

    // Reset clears fault; fetch two words then reset asynchronously.
    #2 rst_n = 1'b0;
    #1 chk("rst1_fault", {31'b0, fault}, 32'd0);
    #3 rst_n = 1'b1;
    step(); chk("bub2_v", {31'b0, IFID_Valid}, 32'd0);
    step(); chk_ifid("r0", 32'h0, 32'h00010203);
    step(); chk_ifid("r4", 32'h4, 32'h04050607);
    #3 rst_n = 1'b0;
    #1;
    chk("async_v", {31'b0, IFID_Valid}, 32'd0);
    chk("async_pc", IFID_PC, 32'h0);
    chk("async_instr", IFID_Instr, 32'h0);
    chk("async_addr", InstrAddr, 32'h0);
    #2 rst_n = 1'b1;
    step(); chk("bub3_v", {31'b0, IFID_Valid}, 32'd0);
    step(); chk_ifid("s0", 32'h0, 32'h00010203);

    // Out-of-range redirect faults; later good redirect is ignored.
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    chk("oor_fault", {31'b0, fault}, 32'd1);
    chk("oor_halt", {31'b0, halted}, 32'd1);
    chk("oor_v", {31'b0, IFID_Valid}, 32'd0);
    chk("oor_addr", InstrAddr, 32'h4);
    redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("ign_addr", InstrAddr, 32'h4);
    chk("ign_halt", {31'b0, halted}, 32'd1);
    chk("ign_fault", {31'b0, fault}, 32'd1);
    step();
    chk("ign_v", {31'b0, IFID_Valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
